// File: rtl/ip_sound_mixer.sv
// ---------------------------------------------------------------------------
// ip_sound_mixer
//
// N-channel sound mixer for cartridge sound sources feeding the PWM DAC.
// A sample strobe snapshots all channel inputs; a sequencer then walks the
// channels one per cycle, multiplying each sample by its CPU-programmed
// volume and accumulating. A final cycle scales the sum back to unity gain,
// saturates to the output width and publishes the result with a clip flag.
//
// Ports:
//   clk        system clock (21.47727 MHz)
//   reset      synchronous active-high reset
//   sample_en  one-cycle strobe that starts a mix
//   ch_in      packed channel samples, channel k at [k*IN_W +: IN_W]
//   vol_wr     volume write strobe
//   vol_addr   channel index for volume write and read-back
//   vol_wdata  volume write data
//   vol_rdata  registered read-back of vol[vol_addr] (0 when out of range)
//   busy       high while a mix is in progress
//   overrun    one-cycle pulse when a sample_en is dropped because busy
//   mix_out    signed mixed sample, held between updates
//   mix_valid  one-cycle pulse when mix_out updates
//   mix_clip   saturation flag belonging to the current mix_out
// ---------------------------------------------------------------------------
module ip_sound_mixer #(
    parameter int                CH_NUM    = 4,
    parameter int                IN_W      = 16,
    parameter int                VOL_W     = 4,
    parameter int                OUT_W     = 17,
    parameter logic [CH_NUM-1:0] CH_SIGNED = 4'b0101
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic [CH_NUM*IN_W-1:0]   ch_in,
    input  logic                     vol_wr,
    input  logic [3:0]               vol_addr,
    input  logic [VOL_W-1:0]         vol_wdata,
    output logic [VOL_W-1:0]         vol_rdata,
    output logic                     busy,
    output logic                     overrun,
    output logic signed [OUT_W-1:0]  mix_out,
    output logic                     mix_valid,
    output logic                     mix_clip
);

    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    // Product of an IN_W signed sample and a zero-extended (VOL_W+1) volume.
    localparam int PW    = IN_W + VOL_W + 1;
    // Wide enough that CH_NUM full-scale products can never overflow.
    localparam int AW    = PW + $clog2(CH_NUM);
    // Comparison width: covers both the shifted accumulator and the output.
    localparam int CW    = ((AW > OUT_W) ? AW : OUT_W) + 1;

    localparam logic [VOL_W-1:0]    VOL_UNITY = VOL_W'(1) << (VOL_W - 1);
    localparam logic signed [CW-1:0] SAT_MAX  = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN  = {{(CW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic [4:0]          CH_NUM_L  = 5'(CH_NUM);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(CH_NUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SAT  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic signed [IN_W-1:0]  ch_s     [CH_NUM];
    logic signed [IN_W-1:0]  snap_reg [CH_NUM];
    logic [VOL_W-1:0]        vol_reg  [CH_NUM];

    logic [IDX_W-1:0]        idx_reg;
    logic signed [AW-1:0]    acc_reg;
    logic signed [OUT_W-1:0] mix_out_reg;
    logic                    mix_valid_reg;
    logic                    mix_clip_reg;
    logic                    overrun_reg;
    logic [VOL_W-1:0]        vol_rdata_reg;

    logic                    start;
    logic                    addr_ok;
    logic [IDX_W-1:0]        vol_idx;

    // Normalise every channel to two's complement. Offset-binary channels
    // have their MSB inverted, which subtracts the midpoint.
    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_norm
        if (CH_SIGNED[gi]) begin : g_signed
            assign ch_s[gi] = ch_in[gi*IN_W +: IN_W];
        end else begin : g_offset
            assign ch_s[gi] = {~ch_in[gi*IN_W + IN_W - 1], ch_in[gi*IN_W +: IN_W-1]};
        end
    end

    assign start   = (state_reg == IDLE) && sample_en;
    assign addr_ok = ({1'b0, vol_addr} < CH_NUM_L);
    assign vol_idx = vol_addr[IDX_W-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sample_en) state_next = ACC;
            ACC:     if (idx_reg == IDX_LAST) state_next = SAT;
            SAT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_reg != IDLE);
    end

    // ---------------- Multiply-accumulate datapath ----------------
    logic signed [IN_W-1:0]  s_sel;
    logic [VOL_W-1:0]        vol_sel;
    logic signed [PW-1:0]    s_ext;
    logic signed [PW-1:0]    v_ext;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    acc_next;
    logic signed [AW-1:0]    acc_shr;
    logic signed [CW-1:0]    sat_in;
    logic signed [OUT_W-1:0] sat_val;
    logic                    sat_clip;

    assign s_sel    = snap_reg[idx_reg];
    // Volume is read before any write on this edge lands, so a write that
    // coincides with this channel's ACC cycle only affects the next mix.
    assign vol_sel  = vol_reg[idx_reg];
    assign s_ext    = PW'(s_sel);
    assign v_ext    = $signed(PW'(vol_sel));
    assign prod     = s_ext * v_ext;
    assign acc_next = acc_reg + AW'(prod);

    // Arithmetic shift removes the unity-gain scale; rounds toward -inf.
    assign acc_shr  = acc_reg >>> (VOL_W - 1);
    assign sat_in   = CW'(acc_shr);

    always_comb begin
        sat_val  = sat_in[OUT_W-1:0];
        sat_clip = 1'b0;
        if (sat_in > SAT_MAX) begin
            sat_val  = SAT_MAX[OUT_W-1:0];
            sat_clip = 1'b1;
        end else if (sat_in < SAT_MIN) begin
            sat_val  = SAT_MIN[OUT_W-1:0];
            sat_clip = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg       <= '0;
            acc_reg       <= '0;
            mix_out_reg   <= '0;
            mix_valid_reg <= 1'b0;
            mix_clip_reg  <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            mix_valid_reg <= 1'b0;
            overrun_reg   <= sample_en && (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (sample_en) begin
                        idx_reg <= '0;
                        acc_reg <= '0;
                    end
                end
                ACC: begin
                    acc_reg <= acc_next;
                    idx_reg <= idx_reg + 1'b1;
                end
                SAT: begin
                    mix_out_reg   <= sat_val;
                    mix_clip_reg  <= sat_clip;
                    mix_valid_reg <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sample snapshot: only loaded on an accepted strobe, so later changes on
    // ch_in cannot disturb a mix in progress. No reset needed.
    always_ff @(posedge clk) begin
        if (start) begin
            for (int k = 0; k < CH_NUM; k++) begin
                snap_reg[k] <= ch_s[k];
            end
        end
    end

    // ---------------- Volume registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < CH_NUM; k++) begin
                vol_reg[k] <= VOL_UNITY;
            end
            vol_rdata_reg <= VOL_UNITY;
        end else begin
            if (vol_wr && addr_ok) begin
                vol_reg[vol_idx] <= vol_wdata;
            end
            vol_rdata_reg <= addr_ok ? vol_reg[vol_idx] : '0;
        end
    end

    assign vol_rdata = vol_rdata_reg;
    assign overrun   = overrun_reg;
    assign mix_out   = mix_out_reg;
    assign mix_valid = mix_valid_reg;
    assign mix_clip  = mix_clip_reg;

endmodule

// File: tb/tb_ip_sound_mixer.sv
// ---------------------------------------------------------------------------
// tb_ip_sound_mixer
//
// Scoreboard bench for ip_sound_mixer with default parameters. Every accepted
// sample strobe pushes the model's expected output; a negedge monitor pops
// and compares whenever mix_valid is seen.
// ---------------------------------------------------------------------------
module tb_ip_sound_mixer;

    localparam logic [3:0] CH_SIGNED = 4'b0101;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_en;
    logic [63:0]        ch_in;
    logic               vol_wr;
    logic [3:0]         vol_addr;
    logic [3:0]         vol_wdata;
    logic [3:0]         vol_rdata;
    logic               busy;
    logic               overrun;
    logic signed [16:0] mix_out;
    logic               mix_valid;
    logic               mix_clip;

    ip_sound_mixer #(
        .CH_NUM    (4),
        .IN_W      (16),
        .VOL_W     (4),
        .OUT_W     (17),
        .CH_SIGNED (CH_SIGNED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sample_en (sample_en),
        .ch_in     (ch_in),
        .vol_wr    (vol_wr),
        .vol_addr  (vol_addr),
        .vol_wdata (vol_wdata),
        .vol_rdata (vol_rdata),
        .busy      (busy),
        .overrun   (overrun),
        .mix_out   (mix_out),
        .mix_valid (mix_valid),
        .mix_clip  (mix_clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint out;
        bit     clip;
    } exp_t;

    exp_t   exp_q[$];
    int     vol_m[4];
    int     checks = 0;
    int     errors = 0;
    int     edge_cnt = 0;
    int     valid_cnt = 0;
    int     valid_edge = 0;
    int     ovr_cnt = 0;
    int     e0 = 0;

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end else begin
            $display("ok   %s: %0d", tag, act);
        end
    endtask

    // Reference model: straightforward integer arithmetic on the channel values.
    function automatic exp_t model(input logic [63:0] ch);
        exp_t   r;
        longint acc = 0;
        longint sh;
        for (int k = 0; k < 4; k++) begin
            logic [15:0] raw;
            longint      s;
            raw = ch[k*16 +: 16];
            if (CH_SIGNED[k]) s = longint'($signed(raw));
            else              s = longint'(raw) - 32768;
            acc += s * vol_m[k];
        end
        sh = acc >>> 3;
        r.clip = 1'b0;
        r.out  = sh;
        if (sh > 65535)       begin r.out = 65535;  r.clip = 1'b1; end
        else if (sh < -65536) begin r.out = -65536; r.clip = 1'b1; end
        return r;
    endfunction

    function automatic logic [63:0] pack4(input logic [15:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (mix_valid) begin
            exp_t e;
            valid_cnt++;
            valid_edge = edge_cnt;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_out", longint'(mix_out), e.out);
                check("sb_clip", longint'(mix_clip), longint'(e.clip));
            end
        end
        if (overrun) ovr_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_mix(input logic [63:0] ch);
        ch_in     = ch;
        sample_en = 1'b1;
        exp_q.push_back(model(ch));
        tick();
        sample_en = 1'b0;
        e0 = edge_cnt;
    endtask

    task automatic wait_valid(input int target);
        for (int i = 0; i < 30 && valid_cnt < target; i++) tick();
        if (valid_cnt < target) check("timeout", valid_cnt, target);
    endtask

    task automatic write_vol(input logic [3:0] addr, input logic [3:0] data);
        vol_wr    = 1'b1;
        vol_addr  = addr;
        vol_wdata = data;
        tick();
        vol_wr = 1'b0;
        if (addr < 4) vol_m[addr] = int'(data);
    endtask

    initial begin
        logic [63:0] ch_a;
        int          vc;
        int          oc;

        reset = 1'b1; sample_en = 1'b0; ch_in = '0;
        vol_wr = 1'b0; vol_addr = 4'd0; vol_wdata = 4'd0;
        for (int k = 0; k < 4; k++) vol_m[k] = 8;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_mix_out", longint'(mix_out), 0);
        check("rst_valid", longint'(mix_valid), 0);
        check("rst_clip", longint'(mix_clip), 0);
        check("rst_overrun", longint'(overrun), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_vol_rdata", longint'(vol_rdata), 8);

        // 1. Basic mix, latency, input changes during ACC
        ch_a = pack4(16'd1000, 16'h812C, 16'hFF38, 16'h8000);
        start_mix(ch_a);
        check("t1_busy", longint'(busy), 1);
        wait_valid(1);
        check("t1_latency", valid_edge - e0, 5);
        check("t1_out", longint'(mix_out), 1100);
        check("t1_clip", longint'(mix_clip), 0);
        start_mix(ch_a);
        tick();
        ch_in = {$urandom(), $urandom()};
        wait_valid(2);
        check("t1_hold_out", longint'(mix_out), 1100);

        // 2. Positive and negative saturation
        for (int k = 0; k < 4; k++) write_vol(4'(k), 4'd15);
        start_mix(pack4(16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF));
        wait_valid(3);
        check("t2_pos_out", longint'(mix_out), 65535);
        check("t2_pos_clip", longint'(mix_clip), 1);
        start_mix(pack4(16'h8000, 16'h0000, 16'h8000, 16'h0000));
        wait_valid(4);
        check("t2_neg_out", longint'(mix_out), -65536);
        check("t2_neg_clip", longint'(mix_clip), 1);

        // 3. Gain and floor rounding
        write_vol(4'd0, 4'd1);
        for (int k = 1; k < 4; k++) write_vol(4'(k), 4'd0);
        start_mix(pack4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000));
        wait_valid(5);
        check("t3_floor_out", longint'(mix_out), -1);
        check("t3_floor_clip", longint'(mix_clip), 0);
        write_vol(4'd0, 4'd0);
        start_mix(pack4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000));
        wait_valid(6);
        check("t3_zero_out", longint'(mix_out), 0);

        // 4. Overrun: strobes at E0, E2, E5, E6
        for (int k = 0; k < 4; k++) write_vol(4'(k), 4'd8);
        ch_a = pack4(16'd500, 16'h8064, 16'hFFF6, 16'h8000);
        ch_in = ch_a;
        vc = valid_cnt;
        oc = ovr_cnt;
        for (int i = 0; i < 7; i++) begin
            sample_en = (i == 0 || i == 2 || i == 5 || i == 6);
            if (i == 0 || i == 6) exp_q.push_back(model(ch_a));
            tick();
        end
        sample_en = 1'b0;
        wait_valid(vc + 2);
        repeat (4) tick();
        check("t4_valid_pulses", valid_cnt - vc, 2);
        check("t4_overruns", ovr_cnt - oc, 2);

        // 5. Volume bus
        write_vol(4'd2, 4'd3);
        check("t5_rd_old", longint'(vol_rdata), 8);
        tick();
        check("t5_rd_new", longint'(vol_rdata), 3);
        write_vol(4'd9, 4'd5);
        tick();
        check("t5_rd_oob", longint'(vol_rdata), 0);
        ch_a = pack4(16'd1000, 16'h8000, 16'h0000, 16'h8000);
        vc = valid_cnt;
        start_mix(ch_a);
        write_vol(4'd0, 4'd2);   // lands on the ACC edge of channel 0
        wait_valid(vc + 1);
        check("t5_old_vol_out", longint'(mix_out), 1000);
        start_mix(ch_a);
        wait_valid(vc + 2);
        check("t5_new_vol_out", longint'(mix_out), 250);

        // 6. Reset mid-mix
        start_mix(pack4(16'd4000, 16'h8000, 16'h0000, 16'h8000));
        tick();
        check("t6_busy_pre", longint'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 4; k++) vol_m[k] = 8;
        check("t6_busy", longint'(busy), 0);
        check("t6_mix_out", longint'(mix_out), 0);
        vc = valid_cnt;
        repeat (8) tick();
        check("t6_no_valid", valid_cnt, vc);
        for (int k = 0; k < 4; k++) begin
            vol_addr = 4'(k);
            tick();
            check("t6_vol_rd", longint'(vol_rdata), 8);
        end
        start_mix(pack4(16'd1000, 16'h812C, 16'hFF38, 16'h8000));
        wait_valid(vc + 1);
        check("t6_after_out", longint'(mix_out), 1100);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
